// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock block-RAM FIFO.
package fifo_pkg;

  // Read-port behaviour of the FIFO.
  typedef enum logic {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } fifo_mode_e;

  // Address width for a given depth. Pointers carry one extra wrap bit.
  function automatic int ptr_len(input int depth);
    return $clog2(depth);
  endfunction

  // Signed occupancy change for one cycle: +1 on write only, -1 on read only.
  function automatic logic signed [1:0] count_delta(input logic wr_acc, input logic rd_acc);
    logic signed [1:0] d;
    d = 2'sd0;
    if (wr_acc && !rd_acc) d = 2'sd1;
    if (!wr_acc && rd_acc) d = -2'sd1;
    return d;
  endfunction

endpackage

// File: rtl/sdp_bram.sv
// Simple-dual-port RAM: one write port, one registered read port.
// The array itself has no reset so that it maps onto block RAM; only the
// read output register is cleared.
module sdp_bram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = ptr_len(DEPTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read port; holds its value until the next read enable.
  always_ff @(posedge clk_i) begin
    if (srst_i)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_bram.sv
// Single-clock FIFO on an inferred simple-dual-port block RAM.
// Standard mode reads straight from the RAM output register; FWFT mode adds
// a prefetch stage (RAM register -> output register) so the head word is
// presented on data_out without a read request.
module sync_fifo_bram
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int PTR_LEN  = ptr_len(DEPTH),
  parameter int FWFT     = 1,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               wr_en,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               rd_en,
  output logic [WIDTH-1:0]   data_out,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [PTR_LEN:0]   count,
  output logic               overflow,
  output logic               underflow,
  input  logic               clr_err
);

  localparam int             CW      = PTR_LEN + 1;
  localparam fifo_mode_e     MODE    = (FWFT != 0) ? MODE_FWFT : MODE_STD;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]  AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0]  AE_C    = CW'(AE_LEVEL);

  logic [CW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d, af_q, af_d, ae_q, ae_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              wr_acc, rd_acc, ram_re, empty_w;
  logic signed [1:0] cnt_dlt;
  logic [WIDTH-1:0]  ram_rdata;

  assign wr_acc = wr_en && !full_q;

  sdp_bram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_LEN)
  ) u_ram (
    .clk_i   (clk),
    .srst_i  (srst),
    .we_i    (wr_acc && !srst),
    .waddr_i (wr_ptr_q[PTR_LEN-1:0]),
    .wdata_i (data_in),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q[PTR_LEN-1:0]),
    .rdata_o (ram_rdata)
  );

  // Next-state for pointers, occupancy, level flags and sticky error flags.
  // rd_ptr advances on RAM reads, count on user pops; in FWFT mode the two
  // differ by the words parked in the prefetch stage.
  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + CW'(1) : wr_ptr_q;
    rd_ptr_d = ram_re ? rd_ptr_q + CW'(1) : rd_ptr_q;
    cnt_dlt  = count_delta(wr_acc, rd_acc);
    count_d  = count_q + {{(CW-2){cnt_dlt[1]}}, cnt_dlt};
    full_d   = (count_d == DEPTH_C);
    af_d     = (count_d >= AF_C);
    ae_d     = (count_d <= AE_C);
    // A new error event wins over a simultaneous clear.
    ovf_d    = (wr_en && full_q)  ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
    udf_d    = (rd_en && empty_w) ? 1'b1 : (clr_err ? 1'b0 : udf_q);
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  if (MODE == MODE_FWFT) begin : g_fwft
    logic [CW-1:0]    ram_cnt;
    logic             mid_vld_q, mid_vld_d, out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             pop, mid_move, fetch;

    // Prefetch control: the RAM output register is the middle stage; it
    // refills whenever it is empty or handing its word to the output stage.
    always_comb begin
      ram_cnt   = wr_ptr_q - rd_ptr_q;
      pop       = rd_en && out_vld_q;
      mid_move  = mid_vld_q && (!out_vld_q || pop);
      fetch     = !srst && (ram_cnt != '0) && (!mid_vld_q || mid_move);
      mid_vld_d = fetch ? 1'b1 : (mid_move ? 1'b0 : mid_vld_q);
      out_vld_d = mid_move ? 1'b1 : (pop ? 1'b0 : out_vld_q);
      out_d     = mid_move ? ram_rdata : out_q;
    end

    // Stage boundary: RAM register -> output register.
    always_ff @(posedge clk) begin
      if (srst) begin
        mid_vld_q <= 1'b0;
        out_vld_q <= 1'b0;
        out_q     <= '0;
      end else begin
        mid_vld_q <= mid_vld_d;
        out_vld_q <= out_vld_d;
        out_q     <= out_d;
      end
    end

    assign ram_re   = fetch;
    assign rd_acc   = pop;
    assign empty_w  = !out_vld_q;
    assign data_out = out_q;
  end else begin : g_std
    // Standard mode: an accepted read loads the RAM output register directly.
    assign rd_acc   = rd_en && (count_q != '0);
    assign ram_re   = rd_acc && !srst;
    assign empty_w  = (count_q == '0);
    assign data_out = ram_rdata;
  end

  assign full         = full_q;
  assign empty        = empty_w;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_bram.sv
// Directed bench for sync_fifo_bram: one FWFT instance and one standard
// instance. Written words are queued as expected read data; per-instance
// monitors pop and compare whenever a word is actually delivered.
module tb_sync_fifo_bram;

  logic clk;
  int   n_checks = 0;
  int   n_err    = 0;

  // FWFT instance signals
  logic       f_srst, f_wr_en, f_rd_en, f_clr;
  logic [7:0] f_din, f_dout;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0] f_count;

  // Standard-mode instance signals
  logic       s_srst, s_wr_en, s_rd_en, s_clr;
  logic [7:0] s_din, s_dout;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic [4:0] s_count;

  logic [7:0] f_q[$];
  logic [7:0] s_q[$];
  logic       s_pend = 1'b0;

  sync_fifo_bram #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
    .clk(clk), .srst(f_srst), .wr_en(f_wr_en), .data_in(f_din), .rd_en(f_rd_en),
    .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_udf),
    .clr_err(f_clr)
  );

  sync_fifo_bram #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_std (
    .clk(clk), .srst(s_srst), .wr_en(s_wr_en), .data_in(s_din), .rd_en(s_rd_en),
    .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_udf),
    .clr_err(s_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // FWFT monitor: a word on data_out is consumed when rd_en is high and empty is low.
  always @(negedge clk) begin
    if (!f_srst && f_rd_en && !f_empty) begin
      if (f_q.size() == 0) chk("fwft_unexpected_pop", {24'h0, f_dout}, 32'hFFFF_FFFF);
      else                 chk("fwft_data", {24'h0, f_dout}, {24'h0, f_q.pop_front()});
    end
  end

  // Standard monitor: data_out carries the word one cycle after an accepted read.
  always @(negedge clk) begin
    if (s_pend) begin
      if (s_q.size() == 0) chk("std_unexpected_pop", {24'h0, s_dout}, 32'hFFFF_FFFF);
      else                 chk("std_data", {24'h0, s_dout}, {24'h0, s_q.pop_front()});
    end
    s_pend = !s_srst && s_rd_en && !s_empty;
  end

  // Read the FWFT instance until it is empty, never reading an empty output.
  task automatic drain_fwft(input string name);
    for (int n = 0; n < 60 && f_count != 0; n++) begin
      f_rd_en = !f_empty;
      tick;
    end
    f_rd_en = 1'b0;
    chk(name, {27'h0, f_count}, 32'd0);
  endtask

  initial begin
    f_srst = 1; f_wr_en = 0; f_rd_en = 0; f_clr = 0; f_din = 0;
    s_srst = 1; s_wr_en = 0; s_rd_en = 0; s_clr = 0; s_din = 0;
    tick; tick;
    f_srst = 0; s_srst = 0;
    tick;

    // Reset state
    chk("rst_empty", {31'h0, f_empty}, 32'd1);
    chk("rst_full",  {31'h0, f_full},  32'd0);
    chk("rst_ae",    {31'h0, f_ae},    32'd1);
    chk("rst_af",    {31'h0, f_af},    32'd0);
    chk("rst_count", {27'h0, f_count}, 32'd0);
    chk("rst_dout",  {24'h0, f_dout},  32'd0);
    chk("rst_ovf",   {31'h0, f_ovf},   32'd0);
    chk("rst_udf",   {31'h0, f_udf},   32'd0);

    // FWFT latency: write at edge 0, visible after edge 2
    f_wr_en = 1; f_din = 8'hA5; f_q.push_back(8'hA5);
    tick; f_wr_en = 0;
    chk("a5_count_e0", {27'h0, f_count}, 32'd1);
    chk("a5_empty_e0", {31'h0, f_empty}, 32'd1);
    tick;
    chk("a5_empty_e1", {31'h0, f_empty}, 32'd1);
    tick;
    chk("a5_empty_e2", {31'h0, f_empty}, 32'd0);
    chk("a5_dout_e2",  {24'h0, f_dout},  32'hA5);
    f_rd_en = 1; tick; f_rd_en = 0;
    chk("a5_empty_pop", {31'h0, f_empty}, 32'd1);
    chk("a5_count_pop", {27'h0, f_count}, 32'd0);

    // Fill to full, watch almost_full and full
    for (int i = 0; i < 16; i++) begin
      f_wr_en = 1; f_din = 8'(i); f_q.push_back(8'(i));
      tick;
      chk("fill_count", {27'h0, f_count}, 32'(i + 1));
      chk("fill_af",    {31'h0, f_af},    32'((i + 1) >= 14));
      chk("fill_full",  {31'h0, f_full},  32'((i + 1) == 16));
    end
    f_din = 8'hFF;
    tick; f_wr_en = 0;
    chk("ovf_set",   {31'h0, f_ovf},   32'd1);
    chk("ovf_count", {27'h0, f_count}, 32'd16);
    chk("ovf_full",  {31'h0, f_full},  32'd1);
    drain_fwft("drain1_count");
    chk("drain1_udf", {31'h0, f_udf},   32'd0);
    chk("drain1_ovf", {31'h0, f_ovf},   32'd1);
    chk("drain1_ae",  {31'h0, f_ae},    32'd1);

    f_clr = 1; tick; f_clr = 0;
    chk("clr1_ovf", {31'h0, f_ovf}, 32'd0);

    // Full FIFO with write and read together
    for (int i = 0; i < 16; i++) begin
      f_wr_en = 1; f_din = 8'(8'h10 + i); f_q.push_back(8'(8'h10 + i));
      tick;
    end
    f_din = 8'hEE; f_rd_en = 1;
    tick; f_wr_en = 0; f_rd_en = 0;
    chk("fullrw_count", {27'h0, f_count}, 32'd15);
    chk("fullrw_ovf",   {31'h0, f_ovf},   32'd1);
    chk("fullrw_full",  {31'h0, f_full},  32'd0);
    drain_fwft("drain2_count");

    // Empty FIFO with write and read together
    f_wr_en = 1; f_din = 8'h77; f_q.push_back(8'h77); f_rd_en = 1;
    tick; f_wr_en = 0; f_rd_en = 0;
    chk("emptyrw_count", {27'h0, f_count}, 32'd1);
    chk("emptyrw_udf",   {31'h0, f_udf},   32'd1);
    // Rejected read in the same cycle as clr_err keeps underflow set
    f_clr = 1; f_rd_en = 1;
    tick; f_rd_en = 0;
    chk("prio_udf", {31'h0, f_udf}, 32'd1);
    chk("prio_ovf", {31'h0, f_ovf}, 32'd0);
    tick; f_clr = 0;
    chk("clr2_udf", {31'h0, f_udf}, 32'd0);
    chk("clr2_ovf", {31'h0, f_ovf}, 32'd0);
    drain_fwft("drain3_count");

    // Streaming with pointer wrap
    for (int i = 0; i < 40; i++) begin
      f_wr_en = 1; f_din = 8'(8'h40 + i); f_q.push_back(8'(8'h40 + i));
      f_rd_en = !f_empty;
      tick;
      chk("stream_count_le3", {31'h0, (f_count <= 5'd3)}, 32'd1);
    end
    f_wr_en = 0;
    drain_fwft("drain4_count");
    chk("stream_ovf", {31'h0, f_ovf}, 32'd0);
    chk("stream_udf", {31'h0, f_udf}, 32'd0);

    // Standard mode: read, then reset mid-stream
    s_wr_en = 1; s_din = 8'h31; s_q.push_back(8'h31); tick;
    s_din = 8'h32; tick;
    s_wr_en = 0; s_rd_en = 1; tick;
    s_rd_en = 0;
    chk("std_pre_rst_dout", {24'h0, s_dout}, 32'h31);
    s_wr_en = 1; s_din = 8'h33; s_srst = 1;
    tick; s_wr_en = 0; s_srst = 0;
    chk("std_rst_count", {27'h0, s_count}, 32'd0);
    chk("std_rst_empty", {31'h0, s_empty}, 32'd1);
    chk("std_rst_full",  {31'h0, s_full},  32'd0);
    chk("std_rst_ae",    {31'h0, s_ae},    32'd1);
    chk("std_rst_dout",  {24'h0, s_dout},  32'd0);
    tick;
    s_wr_en = 1; s_din = 8'h3C; s_q.push_back(8'h3C); tick;
    s_wr_en = 0;
    chk("std_3c_count", {27'h0, s_count}, 32'd1);
    s_rd_en = 1; tick; s_rd_en = 0;
    chk("std_3c_dout",  {24'h0, s_dout},  32'h3C);
    chk("std_3c_empty", {31'h0, s_empty}, 32'd1);
    tick; tick;
    chk("std_udf", {31'h0, s_udf}, 32'd0);

    chk("fwft_queue_left", f_q.size(), 32'd0);
    chk("std_queue_left",  s_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
